// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants, FSM state and operand record for alu_arbiter.
package alu_arb_pkg;

   localparam int NREQ     = 2;
   localparam int ALUFUN_W = 6;
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // One complete ALU operation as latched at accept time
   typedef struct packed {
      logic [DATA_W-1:0]   a;
      logic [DATA_W-1:0]   b;
      logic [ALUFUN_W-1:0] fun;
      logic                sign;
   } alu_op_t;

   // Requester index -> one-hot handshake vector
   function automatic logic [NREQ-1:0] idx2onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and shared-ALU signals of alu_arbiter.
// slave = arbiter side, master = requesters plus the ALU.
interface alu_arbiter_if #(parameter int W = 32);
   import alu_arb_pkg::*;

   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0]          req_ready;
   logic [NREQ*W-1:0]        req_A;
   logic [NREQ*W-1:0]        req_B;
   logic [NREQ*ALUFUN_W-1:0] req_ALUFun;
   logic [NREQ-1:0]          req_Sign;

   logic [NREQ-1:0]          rsp_valid;
   logic [NREQ-1:0]          rsp_ready;
   logic [W-1:0]             rsp_Z;

   logic [W-1:0]             alu_A;
   logic [W-1:0]             alu_B;
   logic [ALUFUN_W-1:0]      alu_ALUFun;
   logic                     alu_Sign;
   logic [W-1:0]             alu_Z;

   modport slave (
      input  req_valid, req_A, req_B, req_ALUFun, req_Sign, rsp_ready, alu_Z,
      output req_ready, rsp_valid, rsp_Z, alu_A, alu_B, alu_ALUFun, alu_Sign
   );

   modport master (
      output req_valid, req_A, req_B, req_ALUFun, req_Sign, rsp_ready, alu_Z,
      input  req_ready, rsp_valid, rsp_Z, alu_A, alu_B, alu_ALUFun, alu_Sign
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-requester grant logic.
// Default: round-robin, the requester not served last wins a tie.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie, 'last' is ignored.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic w_unused_last;
   assign w_unused_last = last;

   // fixed priority: requester 0 dominates
   always_comb begin
      grant = 2'b00;
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
   end
`else
   // round-robin: on a tie, hand the ALU to whoever did not get it last
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// IDLE grants and latches an operation, EXEC captures alu_Z, RESP holds the
// result until the owner takes it. One operation per 3 cycles at best.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed-priority grant.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          reset,
   alu_arbiter_if.slave  bus
);

   state_t          r_state;
   state_t          w_next;
   alu_op_t         r_op;
   logic            r_owner;
   logic [W-1:0]    r_rsp_Z;
   logic            w_last;

   logic [NREQ-1:0] w_grant;
   logic            w_grant_idx;
   logic [NREQ-1:0] w_req_ready;
   logic [NREQ-1:0] w_rsp_valid;
   logic            w_accept;
   logic            w_rsp_done;
   alu_op_t         w_op_arr [NREQ];
   alu_op_t         w_req_op;

   // unpack the per-requester slices into operation records
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_arr[gi] = '{a:    bus.req_A[gi*W +: W],
                              b:    bus.req_B[gi*W +: W],
                              fun:  bus.req_ALUFun[gi*ALUFUN_W +: ALUFUN_W],
                              sign: bus.req_Sign[gi]};
   end

`ifdef ALU_ARB_FIXED_PRIO_EN
   // no history needed for fixed priority
   assign w_last = 1'b1;
`else
   logic r_last;

   // remember who was served last; reset to 1 so requester 0 wins first
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_last <= 1'b1;
      else if (w_rsp_done) r_last <= r_owner;
   end

   assign w_last = r_last;
`endif

   rr_arb2 u_arb (
      .req   (bus.req_valid),
      .last  (w_last),
      .grant (w_grant)
   );

   assign w_grant_idx = w_grant[1];
   assign w_req_op    = w_op_arr[w_grant_idx];
   assign w_accept    = |(bus.req_valid & w_req_ready);
   assign w_rsp_done  = |(w_rsp_valid & bus.rsp_ready);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)   w_next = ST_EXEC;
         ST_EXEC:                 w_next = ST_RESP;
         ST_RESP: if (w_rsp_done) w_next = ST_IDLE;
         default:                 w_next = ST_IDLE;
      endcase
   end

   // handshake outputs; the grant is visible only while idle and out of reset
   always_comb begin
      w_req_ready = '0;
      w_rsp_valid = '0;
      case (r_state)
         ST_IDLE: w_req_ready = reset ? '0 : w_grant;
         ST_RESP: w_rsp_valid = idx2onehot(r_owner);
         default: ;
      endcase
   end

   // latch the winning operation on accept, capture the ALU result in EXEC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op    <= '0;
         r_owner <= 1'b0;
         r_rsp_Z <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= w_req_op;
            r_owner <= w_grant_idx;
         end
         if (r_state == ST_EXEC) r_rsp_Z <= bus.alu_Z;
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_Z      = r_rsp_Z;
   assign bus.alu_A      = r_op.a;
   assign bus.alu_B      = r_op.b;
   assign bus.alu_ALUFun = r_op.fun;
   assign bus.alu_Sign   = r_op.sign;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Plays both requesters
// and the shared ALU; expectations come from a transaction-level model.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int W = 32;
   localparam logic [5:0] FUNS [6] = '{6'b000000, 6'b000001, 6'b011000,
                                       6'b011110, 6'b010110, 6'b110101};

   logic clk = 1'b0;
   logic reset;
   int   n_pass  = 0;
   int   n_total = 0;

   // model state: who was served last, and the operations on offer
   int          m_last;
   logic [31:0] m_a   [2];
   logic [31:0] m_b   [2];
   logic [5:0]  m_fun [2];
   logic        m_sign[2];

   alu_arbiter_if #(.W(W)) bus ();

   alu_arbiter #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference ALU: ADD, SUB, AND, OR, XOR, SLT (signedness from Sign)
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] f, input logic s);
      case (f)
         6'b000000: return a + b;
         6'b000001: return a - b;
         6'b011000: return a & b;
         6'b011110: return a | b;
         6'b010110: return a ^ b;
         6'b110101: return {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
         default:   return 32'd0;
      endcase
   endfunction

   // the shared ALU seen by the arbiter
   always_comb bus.alu_Z = alu_ref(bus.alu_A, bus.alu_B, bus.alu_ALUFun, bus.alu_Sign);

   // grant rule: single valid wins; tie goes to the one not served last
   function automatic logic [1:0] exp_grant(input logic [1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (v[0]) return 2'b01;
      if (v[1]) return 2'b10;
      return 2'b00;
`else
      if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
      return v;
`endif
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0;
         default: return $urandom();
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic s);
      bus.req_A[i*W +: W]      = a;
      bus.req_B[i*W +: W]      = b;
      bus.req_ALUFun[i*6 +: 6] = f;
      bus.req_Sign[i]          = s;
      m_a[i] = a; m_b[i] = b; m_fun[i] = f; m_sign[i] = s;
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < 2; i++)
         set_req(i, rand_word(), rand_word(), FUNS[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b00;
      set_req(0, 32'd0, 32'd0, 6'd0, 1'b0);
      set_req(1, 32'd0, 32'd0, 6'd0, 1'b0);
      step(); step();
      n_total++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); else n_pass++;
      n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_Z !== 32'd0) $display("FAIL reset_rsp_Z got=%h exp=0", bus.rsp_Z); else n_pass++;
      n_total++; if ({bus.alu_A, bus.alu_B} !== 64'd0) $display("FAIL reset_alu_AB got=%h/%h exp=0/0", bus.alu_A, bus.alu_B); else n_pass++;
      n_total++; if ({bus.alu_ALUFun, bus.alu_Sign} !== 7'd0) $display("FAIL reset_alu_fun got=%b/%b exp=0/0", bus.alu_ALUFun, bus.alu_Sign); else n_pass++;
      reset = 1'b0;
      bus.req_valid = 2'b00;
      m_last = 1;
      #1;
      n_total++; if (bus.req_ready !== 2'b00) $display("FAIL idle_no_valid_ready got=%b exp=00", bus.req_ready); else n_pass++;
   endtask

   // req0 5+7: accept at edge t, operands visible after t, result held for the t+2 handshake
   task automatic test_single();
      set_req(0, 32'd5, 32'd7, 6'b000000, 1'b0);
      bus.req_valid = 2'b01;
      bus.rsp_ready = 2'b11;
      #1;
      n_total++; if (bus.req_ready !== 2'b01) $display("FAIL single_grant got=%b exp=01", bus.req_ready); else n_pass++;
      step();
      bus.req_valid = 2'b00;
      n_total++; if (bus.alu_A !== 32'd5 || bus.alu_B !== 32'd7) $display("FAIL single_alu_AB got=%0d/%0d exp=5/7", bus.alu_A, bus.alu_B); else n_pass++;
      n_total++; if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) $display("FAIL single_exec_hs got=%b/%b exp=00/00", bus.rsp_valid, bus.req_ready); else n_pass++;
      step();
      n_total++; if (bus.rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", bus.rsp_valid); else n_pass++;
      n_total++; if (bus.rsp_Z !== 32'd12) $display("FAIL single_rsp_Z got=%0d exp=12", bus.rsp_Z); else n_pass++;
      step();
      m_last = 0;
      n_total++; if (bus.rsp_valid !== 2'b00) $display("FAIL single_after_rsp got=%b exp=00", bus.rsp_valid); else n_pass++;
   endtask

   // both requesters valid from reset: req0 10-3, req1 1+1
   task automatic test_contention();
`ifdef ALU_ARB_FIXED_PRIO_EN
      int order [6] = '{0, 0, 0, 0, 0, 0};
`else
      int order [6] = '{0, 1, 0, 1, 0, 1};
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_last = 1;
      set_req(0, 32'd10, 32'd3, 6'b000001, 1'b0);
      set_req(1, 32'd1,  32'd1, 6'b000000, 1'b0);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      for (int k = 0; k < 6; k++) begin
         logic [1:0] eg;
         eg = (order[k] == 1) ? 2'b10 : 2'b01;
         #1;
         n_total++; if (bus.req_ready !== eg) $display("FAIL contention_grant%0d got=%b exp=%b", k, bus.req_ready, eg); else n_pass++;
         step();
         step();
         n_total++; if (bus.rsp_valid !== eg) $display("FAIL contention_owner%0d got=%b exp=%b", k, bus.rsp_valid, eg); else n_pass++;
         n_total++; if (bus.rsp_Z !== ((order[k] == 1) ? 32'd2 : 32'd7)) $display("FAIL contention_Z%0d got=%0d exp=%0d", k, bus.rsp_Z, (order[k] == 1) ? 2 : 7); else n_pass++;
         step();
         m_last = order[k];
      end
      bus.req_valid = 2'b00;
      #1;
   endtask

   // requester 1 stalls its response; non-owner rsp_ready must not complete it
   task automatic test_backpressure();
      logic [31:0] a1, exp_z;
      a1 = $urandom();
      set_req(1, a1, 32'd9, 6'b000000, 1'b0);
      exp_z = a1 + 32'd9;
      bus.req_valid = 2'b10;
      bus.rsp_ready = 2'b01;
      #1;
      n_total++; if (bus.req_ready !== 2'b10) $display("FAIL bp_grant got=%b exp=10", bus.req_ready); else n_pass++;
      step();
      bus.req_valid = 2'b11;
      set_req(0, $urandom(), $urandom(), 6'b000001, 1'b1);
      step();
      for (int k = 0; k < 5; k++) begin
         n_total++;
         if (bus.rsp_valid !== 2'b10 || bus.rsp_Z !== exp_z || bus.req_ready !== 2'b00)
            $display("FAIL bp_hold%0d got=%b/%h/%b exp=10/%h/00", k, bus.rsp_valid, bus.rsp_Z, bus.req_ready, exp_z);
         else n_pass++;
         step();
      end
      bus.rsp_ready = 2'b10;
      step();
      m_last = 1;
      n_total++; if (bus.req_ready !== exp_grant(2'b11, m_last)) $display("FAIL bp_next_grant got=%b exp=%b", bus.req_ready, exp_grant(2'b11, m_last)); else n_pass++;
      bus.req_valid = 2'b00;
      #1;
      n_total++; if (bus.req_ready !== 2'b00) $display("FAIL cancel_ready got=%b exp=00", bus.req_ready); else n_pass++;
      step();
      n_total++; if (bus.rsp_valid !== 2'b00 || bus.alu_A !== a1) $display("FAIL cancel_no_effect got=%b/%h exp=00/%h", bus.rsp_valid, bus.alu_A, a1); else n_pass++;
   endtask

   // reset while the operation is in EXEC drops it entirely
   task automatic test_reset_exec();
      logic seen;
      set_req(0, 32'h1234_5678, 32'h0000_0042, 6'b000001, 1'b1);
      bus.req_valid = 2'b01;
      bus.rsp_ready = 2'b11;
      step();
      bus.req_valid = 2'b00;
      #2 reset = 1'b1;
      #1;
      n_total++; if (bus.rsp_valid !== 2'b00 || bus.rsp_Z !== 32'd0) $display("FAIL rexec_rsp got=%b/%h exp=00/0", bus.rsp_valid, bus.rsp_Z); else n_pass++;
      n_total++; if ({bus.alu_A, bus.alu_B, bus.alu_ALUFun, bus.alu_Sign} !== '0) $display("FAIL rexec_alu got=%h/%h/%b/%b exp=0", bus.alu_A, bus.alu_B, bus.alu_ALUFun, bus.alu_Sign); else n_pass++;
      step();
      reset = 1'b0;
      m_last = 1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (bus.rsp_valid !== 2'b00) seen = 1'b1;
         step();
      end
      n_total++; if (seen !== 1'b0) $display("FAIL rexec_late_rsp got=1 exp=0"); else n_pass++;
   endtask

   // the arbiter forwards overflow unchanged
   task automatic test_pass_through();
      set_req(0, 32'h7FFF_FFFF, 32'd1, 6'b000000, 1'b1);
      bus.req_valid = 2'b01;
      bus.rsp_ready = 2'b11;
      step();
      bus.req_valid = 2'b00;
      n_total++; if (bus.alu_Z !== 32'h8000_0000 || bus.alu_Sign !== 1'b1) $display("FAIL pass_alu got=%h/%b exp=80000000/1", bus.alu_Z, bus.alu_Sign); else n_pass++;
      step();
      n_total++; if (bus.rsp_Z !== 32'h8000_0000) $display("FAIL pass_rsp_Z got=%h exp=80000000", bus.rsp_Z); else n_pass++;
      step();
      m_last = 0;
   endtask

   // random traffic, stalls and abandoned requests against the model
   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  v, eg, oh;
         logic [31:0] exp_z;
         int          own;
         if ($urandom_range(0, 3) == 0) begin
            bus.req_valid = 2'b00;
            #1;
            n_total++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) $display("FAIL rnd_idle%0d got=%b/%b exp=00/00", n, bus.req_ready, bus.rsp_valid); else n_pass++;
            step();
         end
         rand_reqs();
         v = 2'($urandom_range(1, 3));
         bus.req_valid = v;
         bus.rsp_ready = 2'($urandom_range(0, 3));
         #1;
         eg = exp_grant(v, m_last);
         n_total++; if (bus.req_ready !== eg) $display("FAIL rnd_grant%0d got=%b exp=%b v=%b", n, bus.req_ready, eg, v); else n_pass++;
         own   = eg[1] ? 1 : 0;
         oh    = eg;
         exp_z = alu_ref(m_a[own], m_b[own], m_fun[own], m_sign[own]);
         step();
         n_total++;
         if (bus.alu_A !== m_a[own] || bus.alu_B !== m_b[own] || bus.alu_ALUFun !== m_fun[own] || bus.alu_Sign !== m_sign[own])
            $display("FAIL rnd_operands%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", n, bus.alu_A, bus.alu_B, bus.alu_ALUFun, bus.alu_Sign, m_a[own], m_b[own], m_fun[own], m_sign[own]);
         else n_pass++;
         rand_reqs();
         bus.req_valid = 2'($urandom_range(0, 3));
         step();
         for (int k = $urandom_range(0, 3); k >= 0; k--) begin
            bus.rsp_ready = (k == 0) ? (oh | 2'($urandom_range(0, 3))) : (~oh & 2'($urandom_range(0, 3)));
            rand_reqs();
            bus.req_valid = 2'($urandom_range(0, 3));
            #1;
            n_total++;
            if (bus.rsp_valid !== oh || bus.rsp_Z !== exp_z || bus.req_ready !== 2'b00)
               $display("FAIL rnd_rsp%0d got=%b/%h/%b exp=%b/%h/00", n, bus.rsp_valid, bus.rsp_Z, bus.req_ready, oh, exp_z);
            else n_pass++;
            step();
         end
         m_last = own;
      end
      bus.req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_exec();
      test_pass_through();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
